// File: rtl/seg7_pkg.sv
// rtl/seg7_pkg.sv - segment codes and scan timing helpers for the seven-segment driver
package seg7_pkg;

  // Active-low g..a patterns; the dp bit is added by the driver.
  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_A     = 7'h08;
  localparam logic [6:0] SEG_B     = 7'h03;
  localparam logic [6:0] SEG_C     = 7'h46;
  localparam logic [6:0] SEG_D     = 7'h21;
  localparam logic [6:0] SEG_E     = 7'h06;
  localparam logic [6:0] SEG_F     = 7'h0E;
  localparam logic [6:0] SEG_DASH  = 7'h3F;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  function automatic int calc_slot(input int clk_hz, input int refresh_hz, input int digits);
    return clk_hz / (refresh_hz * digits);
  endfunction

  function automatic int calc_ph(input int slot, input int bright_w);
    return slot / (1 << bright_w);
  endfunction

endpackage

// File: rtl/seg7_decoder.sv
// rtl/seg7_decoder.sv - 4-bit code to active-low seven-segment pattern
module seg7_decoder
  import seg7_pkg::*;
#(
  parameter int HEX_EN = 1
) (
  input  logic [3:0] code,
  output logic [6:0] seg_n
);

  always_comb begin
    seg_n = SEG_DASH;
    case (code)
      4'h0: seg_n = SEG_0;
      4'h1: seg_n = SEG_1;
      4'h2: seg_n = SEG_2;
      4'h3: seg_n = SEG_3;
      4'h4: seg_n = SEG_4;
      4'h5: seg_n = SEG_5;
      4'h6: seg_n = SEG_6;
      4'h7: seg_n = SEG_7;
      4'h8: seg_n = SEG_8;
      4'h9: seg_n = SEG_9;
      4'hA: seg_n = (HEX_EN != 0) ? SEG_A : SEG_DASH;
      4'hB: seg_n = (HEX_EN != 0) ? SEG_B : SEG_DASH;
      4'hC: seg_n = (HEX_EN != 0) ? SEG_C : SEG_DASH;
      4'hD: seg_n = (HEX_EN != 0) ? SEG_D : SEG_DASH;
      4'hE: seg_n = (HEX_EN != 0) ? SEG_E : SEG_DASH;
      default: seg_n = (HEX_EN != 0) ? SEG_F : SEG_DASH;
    endcase
  end

endmodule

// File: rtl/seg7_scan_driver.sv
// rtl/seg7_scan_driver.sv - multiplexed common-anode 7-seg driver with double buffer, LZ blanking and PWM
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int CLK_HZ     = 100_000_000,
  parameter int REFRESH_HZ = 1000,
  parameter int DIGITS     = 4,
  parameter int BRIGHT_W   = 3,
  parameter int HEX_EN     = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [4*DIGITS-1:0]   bcd_ip,
  input  logic [DIGITS-1:0]     dp_ip,
  input  logic                  blank_lz,
  input  logic [BRIGHT_W-1:0]   brightness,
  input  logic                  load,
  output logic [DIGITS-1:0]     anode_n,
  output logic [7:0]            cathode_n,
  output logic                  frame_done
);

  localparam int SLOT = calc_slot(CLK_HZ, REFRESH_HZ, DIGITS);
  localparam int PH   = calc_ph(SLOT, BRIGHT_W);
  localparam int CW   = (SLOT > 1) ? $clog2(SLOT) : 1;
  localparam int DW   = $clog2(DIGITS);

  if (PH < 1) begin : g_ph_check
    $error("seg7_scan_driver: CLK_HZ too low for REFRESH_HZ, DIGITS and BRIGHT_W");
  end

  logic [CW-1:0]       c, c_next;
  logic [DW-1:0]       d, d_next;
  logic                slot_end, frame_end;
  logic [4*DIGITS-1:0] shadow_bcd, active_bcd, src_bcd;
  logic [DIGITS-1:0]   shadow_dp, active_dp, src_dp, lz_blank;
  logic                zero_run;
  logic [3:0]          sel_code;
  logic                sel_dp, sel_blank, lit;
  logic [6:0]          dec_seg;
  logic [31:0]         lit_limit;

  assign slot_end   = (c == CW'(SLOT - 1));
  assign frame_end  = slot_end && (d == DW'(DIGITS - 1));
  assign frame_done = frame_end;

  assign c_next = slot_end ? '0 : c + CW'(1);
  assign d_next = slot_end ? (frame_end ? '0 : d + DW'(1)) : d;

  // The wrap edge computes digit 0 of the new frame, so it must decode the
  // shadow value that active is taking at that same edge.
  assign src_bcd = frame_end ? shadow_bcd : active_bcd;
  assign src_dp  = frame_end ? shadow_dp  : active_dp;

  always_comb begin
    zero_run = 1'b1;
    lz_blank = '0;
    for (int k = DIGITS - 1; k >= 1; k--) begin
      zero_run    = zero_run & (src_bcd[4*k +: 4] == 4'd0);
      lz_blank[k] = blank_lz & zero_run;
    end
  end

  always_comb begin
    sel_code  = '0;
    sel_dp    = 1'b0;
    sel_blank = 1'b0;
    for (int k = 0; k < DIGITS; k++) begin
      if (d_next == DW'(k)) begin
        sel_code  = src_bcd[4*k +: 4];
        sel_dp    = src_dp[k];
        sel_blank = lz_blank[k];
      end
    end
  end

  seg7_decoder #(.HEX_EN(HEX_EN)) u_decoder (
    .code  (sel_code),
    .seg_n (dec_seg)
  );

  // c=0 stays dark so the cathode change never shows on the previous digit.
  assign lit_limit = (32'(brightness) + 32'd1) * 32'(PH);
  assign lit       = (c_next != '0) && (32'(c_next) < lit_limit);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      c          <= '0;
      d          <= '0;
      shadow_bcd <= '0;
      shadow_dp  <= '0;
      active_bcd <= '0;
      active_dp  <= '0;
      anode_n    <= '1;
      cathode_n  <= 8'hFF;
    end else begin
      c <= c_next;
      d <= d_next;
      if (load) begin
        shadow_bcd <= bcd_ip;
        shadow_dp  <= dp_ip;
      end
      if (frame_end) begin
        active_bcd <= shadow_bcd;
        active_dp  <= shadow_dp;
      end
      anode_n <= ~({{(DIGITS-1){1'b0}}, lit} << d_next);
      if (slot_end)
        cathode_n <= {~sel_dp, sel_blank ? SEG_BLANK : dec_seg};
    end
  end

endmodule
